// File: rtl/williams_cmos_arb.sv
// Single-port arbiter for the Williams CMOS RAM. The CPU has priority. The HPS ioctl path is
// stalled with hps_wait, and the CPU is halted once an HPS request has been starved long enough.
module williams_cmos_arb #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 4,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_halt,

    input  logic          hps_wr,
    input  logic          hps_rd,
    input  logic [AW-1:0] hps_addr,
    input  logic [DW-1:0] hps_din,
    output logic [DW-1:0] hps_dout,
    output logic          hps_wait,
    output logic          hps_rdy,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q,

    output logic          dirty,
    input  logic          dirty_clr,
    output logic          err_ovr
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StRdLat,
        StDone
    } state_e;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e        r_state;
    logic [7:0]    r_cnt;
    logic          r_halt;
    logic          r_op_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_hps_dout;
    logic          r_dirty;
    logic          r_err_ovr;

    logic          w_cpu_own;
    logic          w_hps_own;
    logic          w_cpu_wr;
    logic          w_strobe;
    logic [7:0]    w_cnt_inc;

    assign w_cpu_own = cpu_cs & ~r_halt;
    assign w_hps_own = ~w_cpu_own & (r_state == StPend);
    assign w_cpu_wr  = w_cpu_own & cpu_we;
    assign w_strobe  = hps_wr | hps_rd;
    // Saturating increment: the wait counter must never wrap back below MAX_WAIT.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        ram_addr = cpu_addr;
        ram_d    = cpu_din;
        ram_we   = 1'b0;
        if (w_cpu_own) begin
            ram_we = cpu_we;
        end else if (w_hps_own) begin
            ram_addr = r_addr;
            ram_d    = r_data;
            ram_we   = r_op_wr;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_halt     <= 1'b0;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_hps_dout <= '0;
            r_dirty    <= 1'b0;
            r_err_ovr  <= 1'b0;
        end else begin
            if (w_cpu_wr) begin
                r_dirty <= 1'b1;
            end else if (dirty_clr) begin
                r_dirty <= 1'b0;
            end

            if (r_state != StIdle && w_strobe) begin
                r_err_ovr <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (hps_wr) begin
                        r_addr  <= hps_addr;
                        r_data  <= hps_din;
                        r_op_wr <= 1'b1;
                        r_state <= StPend;
                        if (hps_rd) begin
                            r_err_ovr <= 1'b1;
                        end
                    end else if (hps_rd) begin
                        r_addr  <= hps_addr;
                        r_op_wr <= 1'b0;
                        r_state <= StPend;
                    end
                end
                StPend: begin
                    if (w_hps_own) begin
                        r_state <= r_op_wr ? StDone : StRdLat;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Halt takes effect next cycle, which hands the port to the HPS.
                        if (w_cnt_inc >= MaxWait) begin
                            r_halt <= 1'b1;
                        end
                    end
                end
                StRdLat: begin
                    r_hps_dout <= ram_q;
                    r_state    <= StDone;
                end
                StDone: begin
                    r_halt  <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cpu_dout = ram_q;
    assign cpu_halt = r_halt;
    assign hps_dout = r_hps_dout;
    assign hps_wait = (r_state == StPend) || (r_state == StRdLat);
    assign hps_rdy  = (r_state == StDone);
    assign dirty    = r_dirty;
    assign err_ovr  = r_err_ovr;

endmodule

// File: tb/tb_williams_cmos_arb.sv
// Bench for williams_cmos_arb: a behavioural RAM plus a transaction-level reference model
// predicting grant cycle, halt window, port mux, dirty and err_ovr for each HPS request.
module tb_williams_cmos_arb;

    localparam int AW = 10;
    localparam int DW = 4;
    localparam int MW = 16;

    logic          clk_sys;
    logic          reset;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_halt;
    logic          hps_wr;
    logic          hps_rd;
    logic [AW-1:0] hps_addr;
    logic [DW-1:0] hps_din;
    logic [DW-1:0] hps_dout;
    logic          hps_wait;
    logic          hps_rdy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
    logic          dirty;
    logic          dirty_clr;
    logic          err_ovr;

    int total;
    int bad;

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];
    bit            m_dirty;
    bit            m_err;

    williams_cmos_arb #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_halt  (cpu_halt),
        .hps_wr    (hps_wr),
        .hps_rd    (hps_rd),
        .hps_addr  (hps_addr),
        .hps_din   (hps_din),
        .hps_dout  (hps_dout),
        .hps_wait  (hps_wait),
        .hps_rdy   (hps_rdy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_q     (ram_q),
        .dirty     (dirty),
        .dirty_clr (dirty_clr),
        .err_ovr   (err_ovr)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM, read data one cycle after the address.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // mode 0: CPU idle, 1: CPU always selected, 2: alternating 1,0,.. from cycle 1, 3: random
    function automatic bit cs_pick(input int mode, input int c);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (c == 0) ? 1'b0 : (c % 2 == 1);
            default: return ($urandom_range(0, 1) == 1);
        endcase
    endfunction

    // One HPS request issued at cycle 0; the model derives when the HPS gets the port:
    // the first PEND cycle the CPU does not own it, or right after MW cycles of starvation.
    task automatic hps_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int mode, input bit both, input bit inject);
        int            busy;
        int            g;
        int            rdy_c;
        bit            halt_now;
        bit            cs;
        bit            own_cpu;
        bit            fin;
        logic [DW-1:0] exp_dout;
        busy = 0; g = -1; rdy_c = -1; halt_now = 1'b0; fin = 1'b0; exp_dout = '0;
        for (int c = 0; c < 40 && !fin; c++) begin
            cs        = cs_pick(mode, c);
            cpu_cs    = cs;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = (mode == 3) ? 10'($urandom_range(0, 1023)) : 10'h010;
            cpu_din   = 4'($urandom_range(0, 15));
            dirty_clr = (mode == 3) ? ($urandom_range(0, 7) == 0) : 1'b0;
            hps_wr    = 1'b0;
            hps_rd    = 1'b0;
            if (c == 0) begin
                hps_wr = wr; hps_rd = !wr || both; hps_addr = a; hps_din = d;
            end else if (c == 1 && inject) begin
                hps_wr = 1'b1; hps_addr = ~a; hps_din = ~d;
            end
            own_cpu = cs && !halt_now;
            if (c >= 1 && g < 0 && !own_cpu) begin
                g = c;
                rdy_c = c + (wr ? 1 : 2);
                exp_dout = ref_mem[a];
            end
            #1;
            chk("cpu_halt", cpu_halt, halt_now);
            chk("hps_wait", hps_wait, (c >= 1) && (g < 0 || c < rdy_c));
            chk("hps_rdy", hps_rdy, c == rdy_c);
            chk("dirty", dirty, m_dirty);
            chk("err_ovr", err_ovr, m_err);
            if (own_cpu) begin
                chk("ram_addr_cpu", ram_addr, cpu_addr);
                chk("ram_we_cpu", ram_we, cpu_we);
                if (cpu_we) begin
                    chk("ram_d_cpu", ram_d, cpu_din);
                    ref_mem[cpu_addr] = cpu_din;
                end
            end else if (c == g) begin
                chk("ram_addr_hps", ram_addr, a);
                chk("ram_we_hps", ram_we, wr);
                if (wr) begin
                    chk("ram_d_hps", ram_d, d);
                    ref_mem[a] = d;
                end
            end else begin
                chk("ram_we_idle", ram_we, 1'b0);
                chk("ram_addr_idle", ram_addr, cpu_addr);
            end
            if (!wr && c == rdy_c) chk("hps_dout", hps_dout, exp_dout);
            if (own_cpu && cpu_we) m_dirty = 1'b1;
            else if (dirty_clr)    m_dirty = 1'b0;
            if ((c == 0 && wr && both) || (c == 1 && inject)) m_err = 1'b1;
            if (c >= 1 && g < 0) begin
                busy++;
                if (busy >= MW) halt_now = 1'b1;
            end
            if (c == rdy_c) begin
                halt_now = 1'b0;
                fin = 1'b1;
            end
            tick();
        end
        hps_wr = 1'b0; hps_rd = 1'b0; cpu_cs = 1'b0; dirty_clr = 1'b0;
    endtask

    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit clr);
        cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; dirty_clr = clr;
        #1;
        chk("cpu_op_we", ram_we, we);
        chk("cpu_op_addr", ram_addr, a);
        if (we) ref_mem[a] = d;
        tick();
        cpu_cs = 1'b0; cpu_we = 1'b0; dirty_clr = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; m_dirty = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        hps_wr = 1'b0; hps_rd = 1'b0; hps_addr = '0; hps_din = '0; dirty_clr = 1'b0;
        repeat (3) tick();
        chk("rst_halt", cpu_halt, 1'b0);
        chk("rst_wait", hps_wait, 1'b0);
        chk("rst_rdy", hps_rdy, 1'b0);
        chk("rst_dout", hps_dout, 4'h0);
        chk("rst_dirty", dirty, 1'b0);
        chk("rst_err", err_ovr, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        reset = 1'b0;
        tick();

        // Write then read back with the CPU idle.
        hps_txn(1'b1, 10'h155, 4'hA, 0, 1'b0, 1'b0);
        hps_txn(1'b0, 10'h155, 4'h0, 0, 1'b0, 1'b0);
        chk("t1_readback", hps_dout, 4'hA);

        // CPU hogging the port: the HPS wins only after the halt.
        hps_txn(1'b1, 10'h020, 4'h5, 1, 1'b0, 1'b0);
        hps_txn(1'b0, 10'h020, 4'h0, 0, 1'b0, 1'b0);
        chk("t2_readback", hps_dout, 4'h5);
        hps_txn(1'b0, 10'h010, 4'h0, 0, 1'b0, 1'b0);

        // Alternating chip select: HPS slips into the first gap.
        hps_txn(1'b0, 10'h155, 4'h0, 2, 1'b0, 1'b0);
        hps_txn(1'b1, 10'h2F0, 4'h9, 2, 1'b0, 1'b0);

        // Dirty flag: set wins over clear.
        cpu_op(1'b0, 10'h000, 4'h0, 1'b1);
        chk("dirty_clr0", dirty, 1'b0);
        cpu_op(1'b1, 10'h3FF, 4'hC, 1'b0);
        chk("dirty_set", dirty, 1'b1);
        cpu_op(1'b1, 10'h3FF, 4'h7, 1'b1);
        chk("dirty_set_wins", dirty, 1'b1);
        cpu_op(1'b0, 10'h000, 4'h0, 1'b1);
        chk("dirty_clr1", dirty, 1'b0);
        m_dirty = 1'b0;
        hps_txn(1'b0, 10'h3FF, 4'h0, 0, 1'b0, 1'b0);
        chk("dirty_rb", hps_dout, 4'h7);

        // Randomised traffic.
        for (int n = 0; n < 60; n++) begin
            hps_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        // Collisions: simultaneous strobes, then a strobe during PEND.
        hps_txn(1'b1, 10'h0C3, 4'h6, 1, 1'b1, 1'b1);
        chk("t4_err", err_ovr, 1'b1);
        hps_txn(1'b0, 10'h0C3, 4'h0, 0, 1'b0, 1'b0);
        chk("t4_readback", hps_dout, 4'h6);
        hps_txn(1'b0, 10'h33C, 4'h0, 0, 1'b0, 1'b0);

        // Reset while halted in PEND aborts the pending write.
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        hps_wr = 1'b1; hps_addr = 10'h2AA; hps_din = ~ref_mem[10'h2AA];
        tick();
        hps_wr = 1'b0;
        repeat (MW) tick();
        #1;
        chk("t6_halt_pre", cpu_halt, 1'b1);
        chk("t6_wait_pre", hps_wait, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_wait_rst", hps_wait, 1'b0);
        chk("t6_halt_rst", cpu_halt, 1'b0);
        chk("t6_we_rst", ram_we, 1'b0);
        chk("t6_err_rst", err_ovr, 1'b0);
        tick();
        tick();
        reset = 1'b0; cpu_cs = 1'b0;
        m_err = 1'b0; m_dirty = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t6_we_after", ram_we, 1'b0);
            chk("t6_wait_after", hps_wait, 1'b0);
            tick();
        end
        hps_txn(1'b0, 10'h2AA, 4'h0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
